// File: rtl/ab_seq_sched_if.sv
// Handshake bundle between the four requesters and the a->b sequencing scheduler.
// master = requester side (drives req/abort), slave = scheduler side.
// All scheduler outputs are registered inside ab_seq_sched.
interface ab_seq_sched_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       req;
  logic             abort;
  logic [3:0]       gnt;
  logic             seq_a;
  logic             seq_b;
  logic             busy;
  logic [3:0]       done;
  logic [CNT_W-1:0] o_txn_cnt;

  modport master (
    output req, abort,
    input  gnt, seq_a, seq_b, busy, done, o_txn_cnt
  );

  modport slave (
    input  req, abort,
    output gnt, seq_a, seq_b, busy, done, o_txn_cnt
  );
endinterface

// File: rtl/ab_seq_sched.sv
// Round-robin scheduler sharing one a->b sequencer: seq_a, then seq_b exactly GAP cycles later.
// Latency: gnt one cycle after req is seen in IDLE, seq_a one cycle after gnt, seq_b GAP after seq_a.
// No backpressure: req is sampled only in IDLE; later requests wait, abort cancels PH_A/WAIT.
module ab_seq_sched #(
  parameter int GAP   = 10,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ab_seq_sched_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PH_A = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] PH_B = 2'd3;

  logic [1:0]       state;
  logic [1:0]       ptr;
  logic [1:0]       idx;
  logic [7:0]       gap_cnt;
  logic [3:0]       gnt_q;
  logic [3:0]       done_q;
  logic             seq_a_q;
  logic             seq_b_q;
  logic             busy_q;
  logic [CNT_W-1:0] txn_q;

  logic [1:0]       pick_idx;
  logic [3:0]       pick_oh;
  logic             pick_vld;
  logic [1:0]       scan_j;

  // Round-robin pick: first set req bit searching upward from ptr, wrapping mod 4.
  always_comb begin
    pick_idx = ptr;
    pick_vld = 1'b0;
    scan_j   = ptr;
    for (int k = 0; k < 4; k++) begin
      scan_j = ptr + 2'(k);
      if (!pick_vld && bus.req[scan_j]) begin
        pick_vld = 1'b1;
        pick_idx = scan_j;
      end
    end
    pick_oh = 4'b0001 << pick_idx;
  end

  // Sequencer FSM; every output is a register set from the current state, so outputs trail the state by a cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      idx     <= 2'd0;
      gap_cnt <= 8'd0;
      gnt_q   <= 4'd0;
      done_q  <= 4'd0;
      seq_a_q <= 1'b0;
      seq_b_q <= 1'b0;
      busy_q  <= 1'b0;
      txn_q   <= '0;
    end else begin
      seq_a_q <= 1'b0;
      seq_b_q <= 1'b0;
      done_q  <= 4'd0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt_q   <= pick_oh;
            busy_q  <= 1'b1;
            idx     <= pick_idx;
            gap_cnt <= 8'(GAP - 1);
            state   <= PH_A;
          end else begin
            // The previous grant stays visible through the cycle that shows done.
            gnt_q  <= 4'd0;
            busy_q <= 1'b0;
          end
        end
        PH_A: begin
          if (bus.abort) begin
            gnt_q  <= 4'd0;
            busy_q <= 1'b0;
            ptr    <= idx + 2'd1;
            state  <= IDLE;
          end else begin
            seq_a_q <= 1'b1;
            state   <= (GAP > 1) ? WAIT : PH_B;
          end
        end
        WAIT: begin
          if (bus.abort) begin
            gnt_q  <= 4'd0;
            busy_q <= 1'b0;
            ptr    <= idx + 2'd1;
            state  <= IDLE;
          end else if (gap_cnt <= 8'd1) begin
            state <= PH_B;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        PH_B: begin
          // abort is deliberately ignored here: the b phase always completes.
          seq_b_q <= 1'b1;
          done_q  <= gnt_q;
          txn_q   <= txn_q + 1'b1;
          ptr     <= idx + 2'd1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.seq_a     = seq_a_q;
  assign bus.seq_b     = seq_b_q;
  assign bus.busy      = busy_q;
  assign bus.o_txn_cnt = txn_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_ab_excl:     assert property (@(posedge clk) disable iff (!rst_n) !(seq_a_q && seq_b_q));
  a_done_in_gnt: assert property (@(posedge clk) disable iff (!rst_n) (done_q & ~gnt_q) == 4'd0);
  a_busy_gnt:    assert property (@(posedge clk) disable iff (!rst_n) busy_q == (gnt_q != 4'd0));

endmodule
